voter_fault_monitor: RTL and testbench
======================================

Name: voter_fault_monitor

Overview:
- Sits directly downstream of the combinational majority voter.
- Consumes the voted word, the voter's valid flag and the raw replica inputs.
- Registers the voted result onto a valid/ready stream, holding the last good value when no majority exists.
- Tracks per-replica disagreement with leaky-bucket counters and a per-channel health FSM, reporting suspect and failed replicas to the fault manager.

Parameters:
- INPUT_WIDTH, 8, width of each replica word.
- NUM_INPUTS, 3, number of replicas (2..16).
- CNT_WIDTH, 8, per-channel error counter width.
- SUSPECT_THRESH, 4, error count at which a channel becomes SUSPECT.
- FAIL_THRESH, 16, error count at which a channel becomes FAILED; must satisfy SUSPECT_THRESH < FAIL_THRESH <= 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ch_in  input  NUM_INPUTS*INPUT_WIDTH  raw replica words, channel i at bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- vote_in  input  INPUT_WIDTH  voter majority output.
- vote_ok  input  1  voter valid (majority exists).
- in_valid  input  1  sample strobe; ch_in, vote_in and vote_ok are qualified by it.
- in_ready  output  1  monitor can accept a sample.
- out_data  output  INPUT_WIDTH  registered voted word.
- out_stale  output  1  out_data is a held value (no majority on this sample).
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- clear_fault  input  NUM_INPUTS  per-channel pulse: counter to 0, state to HEALTHY.
- chan_suspect  output  NUM_INPUTS  channel state == SUSPECT.
- chan_failed  output  NUM_INPUTS  channel state == FAILED.
- nomaj_cnt  output  16  saturating count of accepted samples with vote_ok=0.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high, ports clk and rst.
- Reset values: out_data=0, out_stale=0, out_valid=0, nomaj_cnt=0, all counters 0, all channels HEALTHY (chan_suspect=0, chan_failed=0).
- Reset mid-stream discards any held output word.
- Handshake: in_ready = !out_valid || out_ready (combinational). A sample is accepted when in_valid && in_ready.
- Latency: out_valid rises the cycle after acceptance. out_data and out_stale stay stable while out_valid && !out_ready. Back-to-back acceptance at 1 word/cycle is supported while out_ready=1.
- Accepted sample with vote_ok=1:
  - out_data <= vote_in, out_stale <= 0.
  - For each channel i: mismatch_i = (ch_in[i] != vote_in).
- Accepted sample with vote_ok=0:
  - out_data keeps its previous value; out_stale <= 1.
  - nomaj_cnt increments, saturating at 0xFFFF.
  - No channel counter or state changes.
- Per-channel counter, judged only on accepted vote_ok=1 samples:
  - mismatch: +1, saturating at 2^CNT_WIDTH-1.
  - match: -1 if nonzero.
- Per-channel FSM, evaluated on the post-update count, new state visible the cycle after acceptance:
  - HEALTHY -> SUSPECT when cnt >= SUSPECT_THRESH.
  - SUSPECT -> HEALTHY when cnt == 0.
  - SUSPECT -> FAILED when cnt >= FAIL_THRESH.
  - FAILED is sticky. The counter keeps updating but the state only leaves FAILED via clear_fault or rst.
  - A single update may move HEALTHY -> FAILED directly only if the thresholds allow it; otherwise transitions go through SUSPECT.
- clear_fault[i] in the same cycle as an accepted sample: clear wins, so the counter is 0 and the state HEALTHY next cycle, and that sample is ignored for channel i. Other channels update normally.
- clear_fault acts regardless of in_valid or in_ready.

Optional Feature:
- Macro VOTER_FAULT_IRQ_EN.
- Defined: adds output fault_irq (1 bit), a single-cycle pulse the cycle after any channel enters FAILED from a non-FAILED state. Simultaneous entries produce one pulse. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package voter_pkg holds:
  - chan_state_t enum: HEALTHY=2'b00, SUSPECT=2'b01, FAILED=2'b10.
  - the nomaj_cnt width constant (16).
- Sub-module voter_chan_health: one replica's counter and FSM.
  - Inputs: clk, rst, upd, mismatch, clear.
  - Output: state.
  - Instantiated NUM_INPUTS times in a generate loop.
- Top level holds the output register, the handshake and nomaj_cnt.

Test Plan:
- Reset, then ch_in={0x5A,0x5A,0x5A}, vote_in=0x5A, vote_ok=1, one strobe, out_ready=1 -> next cycle out_valid=1, out_data=0x5A, out_stale=0, chan_suspect=0, chan_failed=0.
- Channel 2 = 0xFF, others 0x11, vote_in=0x11, 4 accepted samples -> chan_suspect=3'b100 after the 4th; continue to 16 -> chan_failed=3'b100, chan_suspect=0 (fault_irq pulses once when VOTER_FAULT_IRQ_EN is defined).
- Channel 1 at SUSPECT with cnt=4, then 4 matching samples -> cnt=0, state HEALTHY, chan_suspect=0.
- Out_data=0x33, then accepted sample with vote_ok=0 -> out_data=0x33, out_stale=1, nomaj_cnt=1, counters unchanged.
- out_ready=0 with in_valid=1 held -> in_ready=0 after the first word, out_data stable; out_ready=1 -> drains and accepts the next sample with no loss or duplication.
- Channel 0 FAILED, clear_fault=3'b001 asserted in the same cycle as a mismatching sample -> chan_failed[0]=0, counter 0; assert rst mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/voter_pkg.sv
// Shared types and constants for the voter fault monitor.
package voter_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAILED  = 2'b10
  } chan_state_t;

  localparam int unsigned NOMAJ_W = 16;

endpackage

// File: rtl/voter_chan_health.sv
// One replica's leaky-bucket disagreement counter and health FSM.
module voter_chan_health
  import voter_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned SUSPECT_THRESH = 4,
  parameter int unsigned FAIL_THRESH    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd,
  input  logic        mismatch,
  input  logic        clear,
  output chan_state_t state
);

  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SUS_T = CNT_WIDTH'(SUSPECT_THRESH);
  localparam logic [CNT_WIDTH-1:0] FAIL_T = CNT_WIDTH'(FAIL_THRESH);

  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  chan_state_t          state_q, state_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear) begin
      cnt_nxt = '0;
    end else if (upd) begin
      if (mismatch) cnt_nxt = (cnt != '1) ? cnt + ONE : cnt;
      else          cnt_nxt = (cnt != '0) ? cnt - ONE : cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HEALTHY;
    else     state_q <= state_nxt;
  end

  // Transitions judge the post-update count so the new state lands with it.
  always_comb begin
    state_nxt = state_q;
    if (clear) begin
      state_nxt = HEALTHY;
    end else if (upd) begin
      unique case (state_q)
        HEALTHY: begin
          if      (cnt_nxt >= FAIL_T) state_nxt = FAILED;
          else if (cnt_nxt >= SUS_T)  state_nxt = SUSPECT;
        end
        SUSPECT: begin
          if      (cnt_nxt >= FAIL_T) state_nxt = FAILED;
          else if (cnt_nxt == '0)     state_nxt = HEALTHY;
        end
        FAILED:  state_nxt = FAILED;
        default: state_nxt = HEALTHY;
      endcase
    end
  end

  always_comb begin
    state = state_q;
  end

endmodule

// File: rtl/voter_fault_monitor.sv
// Registers the voted word onto a valid/ready stream and tracks replica health.
// Optional fault_irq output is enabled by defining VOTER_FAULT_IRQ_EN.
module voter_fault_monitor
  import voter_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned NUM_INPUTS     = 3,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter int unsigned SUSPECT_THRESH = 4,
  parameter int unsigned FAIL_THRESH    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_INPUTS*INPUT_WIDTH-1:0] ch_in,
  input  logic [INPUT_WIDTH-1:0]            vote_in,
  input  logic                              vote_ok,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [INPUT_WIDTH-1:0]            out_data,
  output logic                              out_stale,
  output logic                              out_valid,
  input  logic                              out_ready,
  input  logic [NUM_INPUTS-1:0]             clear_fault,
  output logic [NUM_INPUTS-1:0]             chan_suspect,
  output logic [NUM_INPUTS-1:0]             chan_failed,
`ifdef VOTER_FAULT_IRQ_EN
  output logic                              fault_irq,
`endif
  output logic [NOMAJ_W-1:0]                nomaj_cnt
);

  logic        accept;
  logic        upd;
  chan_state_t ch_state [NUM_INPUTS];

  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
    upd      = accept && vote_ok;
  end

  // A no-majority sample still produces an output beat, re-sending the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_stale <= 1'b0;
      out_valid <= 1'b0;
      nomaj_cnt <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (vote_ok) begin
        out_data  <= vote_in;
        out_stale <= 1'b0;
      end else begin
        out_stale <= 1'b1;
        if (nomaj_cnt != '1) nomaj_cnt <= nomaj_cnt + NOMAJ_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
    voter_chan_health #(
      .CNT_WIDTH      (CNT_WIDTH),
      .SUSPECT_THRESH (SUSPECT_THRESH),
      .FAIL_THRESH    (FAIL_THRESH)
    ) u_health (
      .clk      (clk),
      .rst      (rst),
      .upd      (upd),
      .mismatch (ch_in[i*INPUT_WIDTH +: INPUT_WIDTH] != vote_in),
      .clear    (clear_fault[i]),
      .state    (ch_state[i])
    );
  end

  always_comb begin
    chan_suspect = '0;
    chan_failed  = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      chan_suspect[i] = (ch_state[i] == SUSPECT);
      chan_failed[i]  = (ch_state[i] == FAILED);
    end
  end

`ifdef VOTER_FAULT_IRQ_EN
  logic [NUM_INPUTS-1:0] failed_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) failed_d <= '0;
    else     failed_d <= chan_failed;
  end

  always_comb begin
    fault_irq = |(chan_failed & ~failed_d);
  end
`endif

endmodule

// File: tb/tb_voter_fault_monitor.sv
// Directed scoreboard bench for voter_fault_monitor (3 replicas, 8-bit words).
module tb_voter_fault_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ch_in;
  logic [7:0]  vote_in;
  logic        vote_ok;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_stale;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  clear_fault;
  logic [2:0]  chan_suspect;
  logic [2:0]  chan_failed;
  logic [15:0] nomaj_cnt;
`ifdef VOTER_FAULT_IRQ_EN
  logic        fault_irq;
`endif

  voter_fault_monitor #(
    .INPUT_WIDTH    (8),
    .NUM_INPUTS     (3),
    .CNT_WIDTH      (8),
    .SUSPECT_THRESH (4),
    .FAIL_THRESH    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_in        (ch_in),
    .vote_in      (vote_in),
    .vote_ok      (vote_ok),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_stale    (out_stale),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .clear_fault  (clear_fault),
    .chan_suspect (chan_suspect),
    .chan_failed  (chan_failed),
`ifdef VOTER_FAULT_IRQ_EN
    .fault_irq    (fault_irq),
`endif
    .nomaj_cnt    (nomaj_cnt)
  );

  always #5 clk = ~clk;

  localparam int ST_H = 0;
  localparam int ST_S = 1;
  localparam int ST_F = 2;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          m_cnt [3];
  int          m_st  [3];
  logic        m_ov;
  logic [7:0]  m_last;
  logic [15:0] m_nomaj;
  logic [8:0]  sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] vec_of(input int st);
    logic [2:0] v = '0;
    for (int i = 0; i < 3; i++) v[i] = (m_st[i] == st);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_st[i]  = ST_H;
    end
    m_ov    = 1'b0;
    m_last  = 8'h00;
    m_nomaj = 16'h0000;
    sb.delete();
  endtask

  task automatic step(input logic v, input logic [23:0] ch, input logic [7:0] vin,
                      input logic ok, input logic ordy, input logic [2:0] clr);
    logic       acc;
    logic [8:0] exp_w;
    logic [2:0] prev_f;
    logic [7:0] byte_i;
    in_valid = v; ch_in = ch; vote_in = vin; vote_ok = ok;
    out_ready = ordy; clear_fault = clr;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_ov || ordy));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        exp_w = ordy ? sb.pop_front() : sb[0];
        chk("out_data", 32'(out_data), 32'(exp_w[7:0]));
        chk("out_stale", 32'(out_stale), 32'(exp_w[8]));
      end
    end
    acc = v && (!m_ov || ordy);
    @(posedge clk);
    #1;
    prev_f = vec_of(ST_F);
    for (int i = 0; i < 3; i++) begin
      byte_i = ch[i*8 +: 8];
      if (clr[i]) begin
        m_cnt[i] = 0;
        m_st[i]  = ST_H;
      end else if (acc && ok) begin
        if (byte_i != vin) m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
        else               m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (m_st[i] == ST_H) begin
          if (m_cnt[i] >= 16)     m_st[i] = ST_F;
          else if (m_cnt[i] >= 4) m_st[i] = ST_S;
        end else if (m_st[i] == ST_S) begin
          if (m_cnt[i] >= 16)     m_st[i] = ST_F;
          else if (m_cnt[i] == 0) m_st[i] = ST_H;
        end
      end
    end
    if (acc) begin
      sb.push_back(ok ? {1'b0, vin} : {1'b1, m_last});
      if (ok) m_last = vin;
      else if (m_nomaj != 16'hFFFF) m_nomaj = m_nomaj + 16'd1;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("chan_suspect", 32'(chan_suspect), 32'(vec_of(ST_S)));
    chk("chan_failed", 32'(chan_failed), 32'(vec_of(ST_F)));
    chk("nomaj_cnt", 32'(nomaj_cnt), 32'(m_nomaj));
`ifdef VOTER_FAULT_IRQ_EN
    chk("fault_irq", 32'(fault_irq), 32'(|(vec_of(ST_F) & ~prev_f)));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_stale"}, 32'(out_stale), 32'd0);
    chk({tag, "_nomaj"}, 32'(nomaj_cnt), 32'd0);
    chk({tag, "_suspect"}, 32'(chan_suspect), 32'd0);
    chk({tag, "_failed"}, 32'(chan_failed), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ch_in = '0; vote_in = '0; vote_ok = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; clear_fault = '0;
    model_reset();
    #12;
    chk_reset_vals("reset");
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Clean first word and its drain
    step(1'b1, 24'h5A5A5A, 8'h5A, 1'b1, 1'b1, 3'b000);
    step(1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 3'b000);

    // Channel 2 drifts: SUSPECT after 4, FAILED after 16
    for (int k = 0; k < 16; k++) step(1'b1, 24'hFF1111, 8'h11, 1'b1, 1'b1, 3'b000);

    // Channel 1 to SUSPECT then back to HEALTHY
    for (int k = 0; k < 4; k++) step(1'b1, 24'h11FF11, 8'h11, 1'b1, 1'b1, 3'b000);
    for (int k = 0; k < 4; k++) step(1'b1, 24'h111111, 8'h11, 1'b1, 1'b1, 3'b000);

    // No-majority sample holds the last good word
    step(1'b1, 24'h333333, 8'h33, 1'b1, 1'b1, 3'b000);
    step(1'b1, 24'h000000, 8'h77, 1'b0, 1'b1, 3'b000);
    step(1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 3'b000);

    // Backpressure: hold 0x41 while stalled, then drain
    step(1'b1, 24'h404040, 8'h40, 1'b1, 1'b0, 3'b000);
    step(1'b1, 24'h414141, 8'h41, 1'b1, 1'b0, 3'b000);
    step(1'b1, 24'h414141, 8'h41, 1'b1, 1'b0, 3'b000);
    step(1'b1, 24'h414141, 8'h41, 1'b1, 1'b1, 3'b000);
    step(1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 3'b000);

    // Channel 0 to FAILED, then clear in the same cycle as a mismatch
    for (int k = 0; k < 16; k++) step(1'b1, 24'h111122, 8'h11, 1'b1, 1'b1, 3'b000);
    step(1'b1, 24'h111122, 8'h11, 1'b1, 1'b1, 3'b001);
    step(1'b1, 24'h111111, 8'h11, 1'b1, 1'b1, 3'b000);

    // Reset while a word is held under backpressure
    step(1'b1, 24'h666666, 8'h66, 1'b1, 1'b0, 3'b000);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    #3 rst = 1'b0;
    step(1'b0, 24'h000000, 8'h00, 1'b0, 1'b1, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
